// File: rtl/io_decode_pkg.sv
// io_decode_pkg: shared state encoding and address-decode constants for the IO decode mux
package io_decode_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [11:0] IO_BASE = 12'hFD0;
  localparam int BASE_LSB = 20;
  localparam int WIN_MSB = 19;
  localparam int WIN_LSB = 16;
endpackage

// File: rtl/io_timeout_ctr.sv
// io_timeout_ctr: loadable down-counter that stops at zero and flags it
module io_timeout_ctr #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] init,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i)
    if (rst_i) cnt <= '0;
    else if (load) cnt <= init;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/io_decode_mux.sv
// io_decode_mux: decodes 0xFD0xxxxx into device windows and routes one bus transaction with timeout
module io_decode_mux
  import io_decode_pkg::*;
#(
  parameter int         NDEV    = 8,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         s_cyc_i,
  input  logic         s_stb_i,
  input  logic         s_we_i,
  input  logic [3:0]   s_sel_i,
  input  logic [31:0]  s_adr_i,
  input  logic [31:0]  s_dat_i,
  output logic         s_ack_o,
  output logic         s_err_o,
  output logic [31:0]  s_dat_o,
  output logic [7:0]   dev_cs_o,
  output logic         dev_cyc_o,
  output logic         dev_stb_o,
  output logic         dev_we_o,
  output logic [3:0]   dev_sel_o,
  output logic [15:0]  dev_adr_o,
  output logic [31:0]  dev_dat_o,
  input  logic [7:0]   dev_ack_i,
  input  logic [255:0] dev_dat_i
);
  state_t     state;
  logic [3:0] win;
  logic [2:0] win_q;
  logic       hit, mapped, ack_sel, cnt_zero;
  always_comb begin
    win     = s_adr_i[WIN_MSB:WIN_LSB];
    hit     = s_cyc_i && s_stb_i && s_adr_i[31:BASE_LSB] == IO_BASE;
    mapped  = int'(win) < NDEV;
    ack_sel = dev_ack_i[win_q];
  end
  io_timeout_ctr #(.W(8)) u_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (state == IDLE && hit && mapped),
    .dec   (state == ACCESS),
    .init  (TIMEOUT),
    .zero  (cnt_zero)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      win_q     <= '0;
      s_ack_o   <= 1'b0;
      s_err_o   <= 1'b0;
      s_dat_o   <= '0;
      dev_cs_o  <= '0;
      dev_cyc_o <= 1'b0;
      dev_stb_o <= 1'b0;
      dev_we_o  <= 1'b0;
      dev_sel_o <= '0;
      dev_adr_o <= '0;
      dev_dat_o <= '0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          if (mapped) begin
            win_q     <= win[2:0];
            dev_cs_o  <= 8'b1 << win[2:0];
            dev_cyc_o <= 1'b1;
            dev_stb_o <= 1'b1;
            dev_we_o  <= s_we_i;
            dev_sel_o <= s_sel_i;
            dev_adr_o <= s_adr_i[15:0];
            dev_dat_o <= s_dat_i;
            state     <= ACCESS;
          end else begin
            s_err_o <= 1'b1;
            state   <= RESP;
          end
        end
        ACCESS: if (ack_sel || !s_cyc_i || cnt_zero) begin
          dev_cs_o  <= '0;
          dev_cyc_o <= 1'b0;
          dev_stb_o <= 1'b0;
          dev_we_o  <= 1'b0;
          dev_sel_o <= '0;
          dev_adr_o <= '0;
          dev_dat_o <= '0;
          s_ack_o   <= ack_sel;
          s_err_o   <= !ack_sel && s_cyc_i;
          s_dat_o   <= ack_sel ? dev_dat_i[{win_q, 5'd0} +: 32] : '0;
          state     <= (ack_sel || s_cyc_i) ? RESP : IDLE;
        end
        RESP: if (!s_stb_i || !s_cyc_i) begin
          s_ack_o <= 1'b0;
          s_err_o <= 1'b0;
          s_dat_o <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/io_decode_mux.md
IO_DECODE_MUX -- requirements
Module: io_decode_mux

Interface
REQ-001 The block SHALL have parameter NDEV, default 8, meaning the number of device windows, fixed range 1..8.
REQ-002 The block SHALL have parameter TIMEOUT, default 8'd255, meaning the number of cycles to wait for a device ack before raising an error.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i  in  1  Single clock.
- rst_i  in  1  Reset, synchronous and active-high.
- s_cyc_i  in  1  Upstream cycle valid.
- s_stb_i  in  1  Upstream strobe.
- s_we_i  in  1  Upstream write enable.
- s_sel_i  in  4  Upstream byte selects.
- s_adr_i  in  32  Upstream address.
- s_dat_i  in  32  Upstream write data.
- s_ack_o  out  1  Ack back to the bridge master port.
- s_err_o  out  1  Bus error (unmapped window or timeout).
- s_dat_o  out  32  Read data back to the bridge.
- dev_cs_o  out  8  One-hot device chip select.
- dev_cyc_o  out  1  Shared device cycle.
- dev_stb_o  out  1  Shared device strobe.
- dev_we_o  out  1  Shared device write enable.
- dev_sel_o  out  4  Shared device byte selects.
- dev_adr_o  out  16  Offset within the window, taken from s_adr_i[15:0].
- dev_dat_o  out  32  Shared device write data.
- dev_ack_i  in  8  Per-device ack.
- dev_dat_i  in  256  Per-device read data; device n occupies bits [32n+31:32n].

Function
REQ-004 Decode: a request is s_cyc_i&s_stb_i with s_adr_i[31:20]==12'hFD0; window = s_adr_i[19:16]; window < NDEV is mapped, window >= NDEV is unmapped.
REQ-005 The state machine SHALL have states IDLE, ACCESS, RESP; encoding is free.
REQ-006 In IDLE, an upstream request whose address is outside 0xFD0xxxxx SHALL be ignored, with no outputs changing.
REQ-007 In IDLE, a mapped request SHALL register dev_cs_o (one-hot at bit window), dev_cyc_o=dev_stb_o=1, and dev_we/sel/adr/dat from the upstream signals; it SHALL load the timeout counter with TIMEOUT and go to ACCESS; device strobe is visible 1 cycle after the request.
REQ-008 In IDLE, an unmapped request SHALL set s_err_o=1 on the next cycle, assert no device strobe, and go to RESP.
REQ-009 In ACCESS, dev_ack_i[window] high SHALL cause the following, on the next cycle: s_dat_o = dev_dat_i[window] slice, s_ack_o=1, device bus cleared, state RESP.
REQ-010 Acks from non-selected devices SHALL be ignored in every state.
REQ-011 In ACCESS, if the selected device has not acked and the counter==0, the block SHALL clear the device bus, set s_err_o=1 and s_dat_o=0, and go to RESP; otherwise the counter SHALL decrement each cycle.
REQ-012 Ack and timeout in the same cycle: ack SHALL win.
REQ-013 In ACCESS, s_cyc_i low with no ack SHALL abort: device bus cleared, no ack/err, IDLE next cycle.
REQ-014 In RESP, s_ack_o/s_err_o SHALL be held until s_stb_i or s_cyc_i is low; then they SHALL clear, s_dat_o SHALL return to 0, and the state SHALL be IDLE; a new request is accepted no earlier than the cycle after.
REQ-015 s_ack_o and s_err_o SHALL never both be 1; dev_cs_o SHALL be all zero whenever dev_cyc_o=0.
REQ-016 "Device bus cleared" SHALL mean dev_cs_o, dev_cyc_o, dev_stb_o, dev_we_o, dev_sel_o, dev_adr_o and dev_dat_o are all 0.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 rst_i high at a clock edge SHALL force state IDLE, every output to 0, and the counter to 0, including when asserted mid-ACCESS or mid-RESP.

Structure
REQ-019 io_decode_pkg SHALL hold the state enum, the IO_BASE constant 12'hFD0, and the window field position [19:16].
REQ-020 The timeout counter SHALL be a sub-module io_timeout_ctr with load, decrement, and zero flag.

Verification
REQ-021 Read 0xFD02_0010, device 2 acks 3 cycles after its strobe with data 0xDEADBEEF -> dev_cs_o=8'h04, dev_adr_o=16'h0010, s_ack_o with s_dat_o=0xDEADBEEF one cycle after the ack.
REQ-022 Write 0xFD00_0004, sel=4'h3, data 0x1234 -> dev_we_o=1, dev_sel_o=4'h3, dev_dat_o=0x1234 to device 0; ack returned; bus idles after s_stb_i drops.
REQ-023 Access 0xFD0A_0000 with NDEV=8 -> s_err_o=1 next cycle, dev_cyc_o never asserted.
REQ-024 TIMEOUT=4, device silent -> s_err_o asserted 5 cycles after the device strobe, with s_dat_o=0.
REQ-025 Device 5 selected, device 3 acks, then s_cyc_i drops -> no s_ack_o, return to IDLE, bus cleared.
REQ-026 rst_i pulsed while in ACCESS -> all outputs 0 the next cycle; a following read to 0xFD01_0000 completes normally.
